gpio_ctrl: RTL

Register-programmed controller for a bank of `pad_gpio` instances. It drives each pad's control pins: pull-up, pull-down, output enable, output value, slew limit and input enable. It samples each pad's returned `input_val` through a two-flop synchronizer and detects rising edges on it. It raises a level interrupt from W1C flags. It sits between the CPU peripheral bus and the pad ring, one instance per GPIO bank.

---
 rtl/gpio_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-programmed pad controller for one GPIO bank, with synchronized inputs and W1C rising-edge interrupts.
// Optional feature macro GPIO_DEBOUNCE_EN adds a per-pin stable-count filter between the synchronizer and IN.
module gpio_ctrl #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic         rd,
    input  logic [3:0]   addr,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic [N-1:0] pullup_en,
    output logic [N-1:0] pulldown_en,
    output logic [N-1:0] output_en,
    output logic [N-1:0] output_val,
    output logic [N-1:0] slew_limit_en,
    output logic [N-1:0] input_en,
    input  logic [N-1:0] input_val,
    output logic         irq
);

    localparam logic [3:0] ADDR_OE   = 4'd0;
    localparam logic [3:0] ADDR_OUT  = 4'd1;
    localparam logic [3:0] ADDR_IN   = 4'd2;
    localparam logic [3:0] ADDR_PUE  = 4'd3;
    localparam logic [3:0] ADDR_PDE  = 4'd4;
    localparam logic [3:0] ADDR_INEN = 4'd5;
    localparam logic [3:0] ADDR_SLEW = 4'd6;
    localparam logic [3:0] ADDR_IEN  = 4'd7;
    localparam logic [3:0] ADDR_FLAG = 4'd8;

    if (N < 1 || N > 32 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_param_check
        $error("gpio_ctrl: parameter out of range");
    end

    logic [N-1:0] oe_q;
    logic [N-1:0] out_q;
    logic [N-1:0] pue_q;
    logic [N-1:0] pde_q;
    logic [N-1:0] inen_q;
    logic [N-1:0] slew_q;
    logic [N-1:0] ien_q;
    logic [N-1:0] flag_q;
    logic [N-1:0] flag_d;
    logic [N-1:0] rdata_q;
    logic [N-1:0] rdata_d;
    logic [N-1:0] s1_q;
    logic [N-1:0] s2_q;
    logic [N-1:0] prev_q;
    logic [N-1:0] filt;
    logic [N-1:0] rise;

`ifdef GPIO_DEBOUNCE_EN
    // filt only follows s2 once s2 has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0] filt_q;
    logic [7:0]   cnt_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    filt_q[i] <= s2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = s2_q;
`endif

    assign rise = filt & ~prev_q & inen_q;

    // A new rise on the same edge as a W1C clear must leave the flag set.
    always_comb begin
        flag_d = flag_q;
        if (wr && addr == ADDR_FLAG) flag_d = flag_d & ~wdata;
        flag_d = flag_d | (rise & ien_q);
    end

    always_comb begin
        rdata_d = '0;
        case (addr)
            ADDR_OE:   rdata_d = oe_q;
            ADDR_OUT:  rdata_d = out_q;
            ADDR_IN:   rdata_d = filt;
            ADDR_PUE:  rdata_d = pue_q;
            ADDR_PDE:  rdata_d = pde_q;
            ADDR_INEN: rdata_d = inen_q;
            ADDR_SLEW: rdata_d = slew_q;
            ADDR_IEN:  rdata_d = ien_q;
            ADDR_FLAG: rdata_d = flag_q;
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_q    <= '0;
            out_q   <= '0;
            pue_q   <= '0;
            pde_q   <= '0;
            inen_q  <= '0;
            slew_q  <= '0;
            ien_q   <= '0;
            flag_q  <= '0;
            rdata_q <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
        end else begin
            if (wr) begin
                case (addr)
                    ADDR_OE:   oe_q   <= wdata;
                    ADDR_OUT:  out_q  <= wdata;
                    ADDR_PUE:  pue_q  <= wdata;
                    ADDR_PDE:  pde_q  <= wdata;
                    ADDR_INEN: inen_q <= wdata;
                    ADDR_SLEW: slew_q <= wdata;
                    ADDR_IEN:  ien_q  <= wdata;
                    default:   ;
                endcase
            end
            // Register reads sample the pre-write state, so a same-cycle wr+rd returns the old value.
            if (rd) rdata_q <= rdata_d;
            flag_q <= flag_d;
            s1_q   <= input_val;
            s2_q   <= s1_q;
            prev_q <= filt;
        end
    end

    assign rdata         = rdata_q;
    assign output_en     = oe_q;
    assign output_val    = out_q;
    assign pullup_en     = pue_q;
    assign pulldown_en   = pde_q & ~pue_q;
    assign input_en      = inen_q;
    assign slew_limit_en = slew_q;
    assign irq           = |flag_q;

endmodule
